sample_stream_player: RTL and testbench
=======================================

Name: sample_stream_player

Overview:
Parametrised multi-channel sample source for the pedal datapath. It holds a loadable buffer of up to DEPTH frames, each frame carrying CHANNELS samples. It plays the frames out at a programmable sample rate over a valid/ready stream, in one-shot or loop mode. It replaces file-driven stimulus with a synthesizable block that can feed pedal_top, for example in place of the ADC path, during bring-up.

Parameters:
DATA_W, 16, bits per channel sample (signed two's complement, passed through unmodified)
CHANNELS, 3, samples per frame
DEPTH, 1024, frames stored; ADDR_W = clog2(DEPTH)
DIV_W, 16, width of sample-rate divider

Ports:
clk  in  1  system clock
RSTB  in  1  asynchronous active-low reset
load_we  in  1  buffer write strobe
load_addr  in  ADDR_W  frame address to write
load_data  in  CHANNELS*DATA_W  frame data; channel 0 in the LSBs
length  in  ADDR_W+1  frames to play (1..DEPTH); sampled at start
rate_div  in  DIV_W  a tick occurs every rate_div+1 cycles; sampled at start
loop_en  in  1  wrap to frame 0 after the last frame; sampled live at each last-frame acceptance
start  in  1  begin playback (single-cycle pulse)
stop  in  1  abort playback (single-cycle pulse)
busy  out  1  high from the cycle after an accepted start until IDLE is re-entered
done  out  1  one-cycle pulse when a one-shot playback completes
m_valid  out  1  output frame valid
m_ready  in  1  downstream accept
m_data  out  CHANNELS*DATA_W  frame samples
m_index  out  ADDR_W  frame index of m_data
m_last  out  1  m_data is frame length-1
overrun_cnt  out  16  ticks dropped because the previous frame was still pending; saturating

Behaviour:
- Reset (RSTB low, asynchronous):
  - All outputs are 0; state is IDLE.
  - ptr, tick counter and overrun_cnt are 0; any pending stop is cleared.
  - Buffer contents are not reset.
- Buffer:
  - Single-port synchronous RAM, DEPTH x CHANNELS*DATA_W, with a 1-cycle read.
  - A write happens on load_we only in IDLE. A load_we while busy is dropped.
  - load_addr >= DEPTH is dropped.
- States: IDLE, PLAY, DONE.
- IDLE:
  - On start with 1 <= length <= DEPTH and stop low: latch length and rate_div, set ptr=0, preload the tick counter to rate_div, clear overrun_cnt, go to PLAY.
  - A start with length==0 or length>DEPTH is ignored.
  - start together with stop: stop wins, stay in IDLE.
- PLAY tick generation:
  - The counter increments each cycle. A tick fires when counter==rate_div, and the counter then returns to 0.
  - The first tick therefore fires in the first PLAY cycle. rate_div=0 gives a tick every cycle.
- PLAY on a tick:
  - If no frame is pending (m_valid=0 and no read in flight), issue a read at ptr.
  - The next cycle sets m_valid=1, m_data=mem[ptr], m_index=ptr, and m_last=(ptr==length-1).
  - If a frame is pending, the tick is dropped, overrun_cnt increments (holding at 16'hFFFF), and ptr does not advance.
- Start-to-valid latency: start seen at edge N; busy=1 and first read at N+1; m_valid=1 at N+2.
- Handshake:
  - m_data, m_index and m_last stay stable while m_valid=1 and m_ready=0.
  - A transfer occurs when m_valid and m_ready are both high at a rising edge; m_valid then drops next cycle unless a new read was issued in that same transfer cycle.
  - On transfer with m_last=0: ptr<=ptr+1.
  - On transfer with m_last=1 and loop_en=1: ptr<=0, stay in PLAY.
  - On transfer with m_last=1 and loop_en=0: go to DONE.
  - A tick coinciding with the transfer cycle is treated as not pending, so the read is issued at the updated ptr.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- stop in PLAY:
  - No new reads are issued from the stop cycle onward.
  - If no frame is pending or in flight, go to IDLE next cycle.
  - Otherwise keep the pending frame valid until it is accepted, then go to IDLE.
  - done is not asserted on a stop.
- start while busy is ignored.
- Reset mid-playback returns to IDLE immediately with m_valid=0.

Test Plan:
1. Load frames 0..3 with ch0=k, ch1=-k, ch2=100+k; length=4, rate_div=0, loop_en=0, m_ready=1, start -> m_valid first at start+2; 4 transfers at m_index 0,1,2,3 with matching data; m_last only on index 3; done pulse once; busy low after; overrun_cnt=0.
2. Same buffer, rate_div=9, m_ready=1 -> consecutive m_valid rising edges 10 cycles apart; each frame valid for 1 cycle.
3. length=3, loop_en=1, rate_div=1, run for 20 transfers -> m_index sequence 0,1,2,0,1,2,...; no done; clear loop_en before an index-2 transfer -> done after that transfer.
4. rate_div=0, m_ready held low 5 cycles after the first m_valid -> m_data stable for those 5 cycles; overrun_cnt=4 or 5 depending on tick alignment (bench checks the exact count against the tick model); ptr unchanged; after release, the next m_index is 1 (no frames skipped).
5. Mid-playback stop with a frame pending and m_ready=0 -> frame held; raise m_ready -> one transfer, then IDLE with no done; a load_we issued during busy leaves the RAM unchanged (verified by replay).
6. RSTB low for 2 cycles during PLAY -> all outputs 0 asynchronously; start with length=0 is ignored; start with length=1 -> single frame, m_last=1, done.

Source files
------------

// File: rtl/sample_stream_player.sv
// Multi-channel sample source: a loadable frame buffer played out over a
// valid/ready stream at a programmable tick rate, in one-shot or loop mode.
module sample_stream_player #(
  parameter  int DATA_W   = 16,
  parameter  int CHANNELS = 3,
  parameter  int DEPTH    = 1024,
  parameter  int DIV_W    = 16,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int FRAME_W  = CHANNELS * DATA_W
) (
  input  logic               clk,
  input  logic               RSTB,
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [FRAME_W-1:0] load_data,
  input  logic [ADDR_W:0]    length,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FRAME_W-1:0] m_data,
  output logic [ADDR_W-1:0]  m_index,
  output logic               m_last,
  output logic [15:0]        overrun_cnt
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  CNT_ONE = DIV_W'(1);

  logic [FRAME_W-1:0] mem [DEPTH];

  state_t             state_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [ADDR_W:0]    len_q;
  logic [DIV_W-1:0]   rate_q;
  logic [DIV_W-1:0]   cnt_q;
  logic               stop_q;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic [FRAME_W-1:0] data_q;
  logic [ADDR_W-1:0]  index_q;
  logic               last_q;
  logic [15:0]        ovr_q;

  logic               tick;
  logic               xfer;
  logic               halt;
  logic               last_go;
  logic               rd_en;
  logic               ovr_inc;
  logic               start_ok;
  logic               wr_ok;
  logic [ADDR_W-1:0]  ptr_d;

  // Per-cycle decisions: tick, handshake, where the next read comes from.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    tick     = (state_q == PLAY) && (cnt_q == rate_q);
    xfer     = valid_q && m_ready;
    halt     = stop || stop_q;
    last_go  = xfer && last_q && !loop_en;
    ptr_d    = ptr_q;
    if (xfer) begin
      ptr_d = last_q ? '0 : ptr_q + PTR_ONE;
    end
    // A frame accepted this cycle frees the slot, so a coinciding tick reads
    // the following frame instead of being dropped.
    rd_en    = tick && !halt && (!valid_q || xfer) && !last_go;
    ovr_inc  = tick && !halt && valid_q && !xfer;
    start_ok = start && !stop && (length != '0) && (length <= MAX_LEN);
    wr_ok    = (state_q == IDLE) && load_we && ({1'b0, load_addr} < MAX_LEN);
  end

  // Frame buffer write port; only open while idle so playback reads are never
  // disturbed.
  // NOTE: the RAM array has no reset; clearing it would prevent block-RAM
  // mapping and nothing depends on its power-up contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  // Playback controller with registered stream and status outputs.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      rate_q  <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= PLAY;
            busy_q  <= 1'b1;
            len_q   <= length;
            rate_q  <= rate_div;
            cnt_q   <= rate_div;  // first tick lands in the first PLAY cycle
            ptr_q   <= '0;
            ovr_q   <= '0;
            stop_q  <= 1'b0;
          end
        end
        PLAY: begin
          cnt_q <= tick ? '0 : cnt_q + CNT_ONE;
          ptr_q <= ptr_d;
          if (ovr_inc && ovr_q != 16'hFFFF) begin
            ovr_q <= ovr_q + 16'd1;
          end
          if (rd_en) begin
            valid_q <= 1'b1;
            data_q  <= mem[ptr_d];
            index_q <= ptr_d;
            last_q  <= ({1'b0, ptr_d} == len_q - LEN_ONE);
          end else if (xfer) begin
            valid_q <= 1'b0;
          end
          if (halt && (!valid_q || xfer)) begin
            // Nothing left to deliver: abort without a done pulse.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
          end else if (halt) begin
            stop_q <= 1'b1;  // hold the pending frame until it is taken
          end else if (last_go) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_index     = index_q;
  assign m_last      = last_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_sample_stream_player.sv
// Self-checking bench for sample_stream_player: directed scenarios plus
// randomized one-shot runs scored against a frame-sequence and tick model.
module tb_sample_stream_player;

  localparam int DATA_W   = 16;
  localparam int CHANNELS = 3;
  localparam int DEPTH    = 12;
  localparam int DIV_W    = 16;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int FRAME_W  = CHANNELS * DATA_W;

  logic               clk = 1'b0;
  logic               RSTB;
  logic               load_we;
  logic [ADDR_W-1:0]  load_addr;
  logic [FRAME_W-1:0] load_data;
  logic [ADDR_W:0]    length;
  logic [DIV_W-1:0]   rate_div;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               busy;
  logic               done;
  logic               m_valid;
  logic               m_ready;
  logic [FRAME_W-1:0] m_data;
  logic [ADDR_W-1:0]  m_index;
  logic               m_last;
  logic [15:0]        overrun_cnt;

  sample_stream_player #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .RSTB(RSTB),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .length(length), .rate_div(rate_div), .loop_en(loop_en),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: buffer image plus observed stream bookkeeping.
  typedef struct {
    int                 idx;
    logic [FRAME_W-1:0] data;
    logic               last;
  } xfer_t;

  logic [FRAME_W-1:0] ref_mem [DEPTH];
  xfer_t              xq[$];
  int                 rise_q[$];
  int                 cur_rate;
  int                 n_checks;
  int                 n_errors;

  int                 cyc, k_play, exp_ovr, start_cyc, busy_cyc;
  int                 done_cnt, valid_cyc_cnt, stable_viol, done_busy_viol;
  logic               prev_valid = 1'b0, prev_busy = 1'b0, prev_stall = 1'b0;
  logic [FRAME_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0]  prev_idx = '0;
  logic               prev_last = 1'b0;

  // Monitor: records transfers, valid rises, done pulses, stall stability and
  // the expected overrun count (ticks every cur_rate+1 PLAY cycles, starting
  // with the first one, dropped whenever a frame is waiting and not taken).
  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_valid <= m_valid;
    prev_busy  <= busy;
    prev_stall <= m_valid && !m_ready;
    prev_data  <= m_data;
    prev_idx   <= m_index;
    prev_last  <= m_last;
    if (start) begin
      start_cyc      <= cyc;
      k_play         <= 0;
      exp_ovr        <= 0;
      done_cnt       <= 0;
      valid_cyc_cnt  <= 0;
      stable_viol    <= 0;
      done_busy_viol <= 0;
      xq.delete();
      rise_q.delete();
    end else begin
      if (busy) begin
        if ((k_play % (cur_rate + 1)) == 0 && m_valid && !m_ready) exp_ovr <= exp_ovr + 1;
        k_play <= k_play + 1;
      end
      if (busy && !prev_busy) busy_cyc <= cyc;
      if (m_valid) valid_cyc_cnt <= valid_cyc_cnt + 1;
      if (m_valid && !prev_valid) rise_q.push_back(cyc);
      if (m_valid && m_ready) xq.push_back('{idx: int'(m_index), data: m_data, last: m_last});
      if (done) done_cnt <= done_cnt + 1;
      if (done && busy) done_busy_viol <= done_busy_viol + 1;
      if (prev_stall && !(m_valid && m_data == prev_data && m_index == prev_idx && m_last == prev_last))
        stable_viol <= stable_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_W-1:0] rnd_frame();
    logic [FRAME_W-1:0] f;
    for (int c = 0; c < CHANNELS; c++) f[c*DATA_W +: DATA_W] = DATA_W'($urandom());
    return f;
  endfunction

  task automatic load(input int a, input logic [FRAME_W-1:0] d, input bit upd);
    load_addr = a[ADDR_W-1:0];
    load_data = d;
    load_we   = 1'b1;
    cycle();
    load_we   = 1'b0;
    if (upd && a < DEPTH) ref_mem[a] = d;
  endtask

  task automatic play(input int len, input int rate, input logic lp);
    length   = len[ADDR_W:0];
    rate_div = rate[DIV_W-1:0];
    cur_rate = rate;
    loop_en  = lp;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!m_valid && i < 50) begin
      cycle();
      i++;
    end
    check(tag, m_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd);
    int i = 0;
    while (busy && i < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      cycle();
      i++;
    end
    check({tag, "_idle_reached"}, busy, 1'b0);
    cycle();
    cycle();
  endtask

  // Expected one-shot stream: frames 0..len-1 in order, last flag on len-1.
  task automatic check_oneshot(input string tag, input int len);
    check({tag, "_count"}, xq.size(), len);
    for (int j = 0; j < len && j < xq.size(); j++) begin
      check($sformatf("%s_idx%0d", tag, j), xq[j].idx, j);
      check($sformatf("%s_data%0d", tag, j), xq[j].data, ref_mem[j]);
      check($sformatf("%s_last%0d", tag, j), xq[j].last, (j == len - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] c0, c1, c2;
    int                nk, len, rate;

    RSTB = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    length = '0; rate_div = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    m_ready = 1'b0; cur_rate = 0;
    #1 RSTB = 1'b0;
    repeat (3) cycle();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, '0);
    check("rst_index", m_index, '0);
    check("rst_last", m_last, 1'b0);
    check("rst_ovr", overrun_cnt, '0);
    RSTB = 1'b1;
    cycle();

    // 1: basic one-shot, back-to-back frames.
    for (int k = 0; k < DEPTH; k++) begin
      if (k < 4) begin
        nk = -k;
        c0 = k[DATA_W-1:0];
        c1 = nk[DATA_W-1:0];
        c2 = DATA_W'(100 + k);
        load(k, {c2, c1, c0}, 1'b1);
      end else begin
        load(k, rnd_frame(), 1'b1);
      end
    end
    m_ready = 1'b1;
    play(4, 0, 1'b0);
    wait_idle("t1", 100, 1'b0);
    check("t1_busy_latency", busy_cyc - start_cyc, 1);
    check("t1_valid_latency", (rise_q.size() > 0 ? rise_q[0] : -100) - start_cyc, 2);
    check_oneshot("t1", 4);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_busy", done_busy_viol, 0);
    check("t1_busy_after", busy, 1'b0);
    check("t1_ovr", overrun_cnt, 16'd0);

    // 2: divided rate, frames spaced rate_div+1 cycles apart.
    play(4, 9, 1'b0);
    wait_idle("t2", 200, 1'b0);
    check("t2_rises", rise_q.size(), 4);
    for (int i = 1; i < rise_q.size(); i++)
      check($sformatf("t2_spacing%0d", i), rise_q[i] - rise_q[i-1], cur_rate + 1);
    check("t2_valid_cycles", valid_cyc_cnt, 4);
    check_oneshot("t2", 4);
    check("t2_ovr", overrun_cnt, exp_ovr);

    // 3: loop mode, then release the loop before an index-2 transfer.
    play(3, 1, 1'b1);
    for (int i = 0; i < 500 && xq.size() < 20; i++) cycle();
    check("t3_reached20", xq.size(), 20);
    check("t3_no_done", done_cnt, 0);
    loop_en = 1'b0;
    wait_idle("t3", 200, 1'b0);
    check("t3_count", xq.size(), 21);
    for (int j = 0; j < xq.size(); j++) begin
      check($sformatf("t3_idx%0d", j), xq[j].idx, j % 3);
      check($sformatf("t3_data%0d", j), xq[j].data, ref_mem[j % 3]);
      check($sformatf("t3_last%0d", j), xq[j].last, (j % 3 == 2));
    end
    check("t3_done_cnt", done_cnt, 1);

    // 4: backpressure for 5 cycles; frame held, ticks dropped, none skipped.
    m_ready = 1'b0;
    play(4, 0, 1'b0);
    wait_valid("t4_valid");
    repeat (4) cycle();
    check("t4_hold_data", m_data, ref_mem[0]);
    check("t4_hold_index", m_index, '0);
    cycle();
    m_ready = 1'b1;
    wait_idle("t4", 100, 1'b0);
    check_oneshot("t4", 4);
    check("t4_ovr", overrun_cnt, exp_ovr);
    check("t4_stable", stable_viol, 0);

    // 5: stop with a held frame; load attempts while busy / out of range.
    load(13, rnd_frame(), 1'b1);
    m_ready = 1'b0;
    play(4, 0, 1'b0);
    wait_valid("t5_valid");
    stop      = 1'b1;
    load_we   = 1'b1;
    load_addr = ADDR_W'(2);
    load_data = ~ref_mem[2];
    cycle();
    stop    = 1'b0;
    load_we = 1'b0;
    repeat (3) cycle();
    check("t5_held_valid", m_valid, 1'b1);
    check("t5_held_index", m_index, '0);
    check("t5_held_busy", busy, 1'b1);
    m_ready = 1'b1;
    cycle();
    check("t5_stopped_busy", busy, 1'b0);
    check("t5_stopped_valid", m_valid, 1'b0);
    cycle();
    cycle();
    check("t5_one_xfer", xq.size(), 1);
    check("t5_no_done", done_cnt, 0);
    play(4, 0, 1'b0);
    wait_idle("t5_replay", 100, 1'b0);
    check_oneshot("t5_replay", 4);

    // 6: asynchronous reset mid-play, rejected starts, single-frame run.
    play(4, 2, 1'b0);
    repeat (3) cycle();
    check("t6_busy_before_rst", busy, 1'b1);
    #2 RSTB = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", m_valid, 1'b0);
    check("t6_rst_data", m_data, '0);
    check("t6_rst_index", m_index, '0);
    check("t6_rst_last", m_last, 1'b0);
    check("t6_rst_ovr", overrun_cnt, '0);
    repeat (2) cycle();
    RSTB = 1'b1;
    cycle();
    play(0, 0, 1'b0);
    cycle();
    check("t6_len0_ignored", busy, 1'b0);
    play(DEPTH + 1, 0, 1'b0);
    cycle();
    check("t6_len_over_ignored", busy, 1'b0);
    stop = 1'b1;
    play(2, 0, 1'b0);
    stop = 1'b0;
    cycle();
    check("t6_start_stop_ignored", busy, 1'b0);
    play(1, 0, 1'b0);
    wait_idle("t6_len1", 100, 1'b0);
    check_oneshot("t6_len1", 1);
    check("t6_done_cnt", done_cnt, 1);

    // 7: randomized one-shot runs with random backpressure.
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 3; w++) load($urandom_range(0, 15), rnd_frame(), 1'b1);
      len  = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
      rate = $urandom_range(0, 3);
      play(len, rate, 1'b0);
      wait_idle($sformatf("t7_%0d", it), 2000, 1'b1);
      check_oneshot($sformatf("t7_%0d", it), len);
      check($sformatf("t7_%0d_ovr", it), overrun_cnt, exp_ovr);
      check($sformatf("t7_%0d_stable", it), stable_viol, 0);
      check($sformatf("t7_%0d_done", it), done_cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
